// File: rtl/coin_program_sequencer.sv
// Coin-triggered program sequencer: queues coin events and streams the matching
// program ROM words to a datapath with a valid/ready handshake.
module coin_program_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [18:0] END_MARKER = 19'h7f000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_5,
  input  logic        coin_10,
  input  logic        coin_25,
  output logic [1:0]  rom_sel,
  output logic [2:0]  rom_addr,
  input  logic [18:0] rom_data,
  output logic [18:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        prog_done,
  output logic        coin_drop,
  output logic [3:0]  pending
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DepthCnt = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        fifo_q [FIFO_DEPTH];
  logic [1:0]        fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;
  logic [1:0]        rom_sel_q, rom_sel_d;
  logic [2:0]        rom_addr_q, rom_addr_d;
  logic [18:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              busy_q, busy_d;
  logic              prog_done_q, prog_done_d;
  logic              coin_drop_q, coin_drop_d;

  logic              coin_any, coin_multi, push, pop, full;
  logic [1:0]        coin_code;

  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rom_sel_d     = rom_sel_q;
    rom_addr_d    = rom_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;

    coin_any   = coin_5 | coin_10 | coin_25;
    coin_multi = (coin_25 & (coin_10 | coin_5)) | (coin_10 & coin_5);
    coin_code  = coin_25 ? 2'd2 : (coin_10 ? 2'd1 : 2'd0);

    // Only IDLE pops, so a full queue can still accept a coin on a popping edge.
    pop  = (state_q == StIdle) && (count_q != 4'd0);
    full = (count_q == DepthCnt);
    push = coin_any && (!full || pop);

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          rom_sel_d  = fifo_q[rd_ptr_q];
          rom_addr_d = 3'd1;
          state_d    = StFetch;
        end else begin
          rom_addr_d = 3'd0;
        end
      end
      StFetch: begin
        if (rom_data == END_MARKER) begin
          state_d = StDone;
        end else begin
          instr_d       = rom_data;
          instr_valid_d = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (rom_addr_q == 3'd7) begin
            state_d = StDone;
          end else begin
            rom_addr_d = rom_addr_q + 3'd1;
            state_d    = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = coin_code;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + {3'b000, push} - {3'b000, pop};

    coin_drop_d = coin_multi || (coin_any && !push);
    prog_done_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      fifo_q        <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rom_sel_q     <= '0;
      rom_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      prog_done_q   <= 1'b0;
      coin_drop_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rom_sel_q     <= rom_sel_d;
      rom_addr_q    <= rom_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      prog_done_q   <= prog_done_d;
      coin_drop_q   <= coin_drop_d;
    end
  end

  assign rom_sel     = rom_sel_q;
  assign rom_addr    = rom_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign prog_done   = prog_done_q;
  assign coin_drop   = coin_drop_q;
  assign pending     = count_q;

endmodule

// File: tb/tb_coin_program_sequencer.sv
// Bench for coin_program_sequencer: directed scenarios plus random coin bursts checked
// against a program-expansion model (coin -> list of ROM words up to the end marker).
module tb_coin_program_sequencer;

  localparam logic [18:0] EndMark = 19'h7f000;

  logic        clk;
  logic        rst;
  logic        coin_5, coin_10, coin_25;
  logic [1:0]  rom_sel;
  logic [2:0]  rom_addr;
  logic [18:0] rom_data;
  logic [18:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy, prog_done, coin_drop;
  logic [3:0]  pending;

  coin_program_sequencer #(
    .FIFO_DEPTH(4),
    .END_MARKER(EndMark)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_5     (coin_5),
    .coin_10    (coin_10),
    .coin_25    (coin_25),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy       (busy),
    .prog_done  (prog_done),
    .coin_drop  (coin_drop),
    .pending    (pending)
  );

  logic [18:0] rom [4][8];
  assign rom_data = rom[rom_sel][rom_addr];

  typedef struct packed {
    logic [1:0]  sel;
    logic [18:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_done = 0;
  int   seen_done = 0;
  int   exp_drops = 0;
  int   seen_drops = 0;
  int   issued = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    assert (got === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // A coin expands to the words at addresses 1..7 of its ROM, stopping at the end marker.
  task automatic add_program(input logic [1:0] code);
    for (int a = 1; a < 8; a++) begin
      if (rom[code][a] == EndMark) break;
      exp_q.push_back('{sel: code, word: rom[code][a]});
    end
    exp_done++;
  endtask

  // One clock: drive inputs, check outputs of the current cycle, advance past the edge.
  task automatic cycle(input logic c5, input logic c10, input logic c25, input logic rdy);
    coin_5 = c5;
    coin_10 = c10;
    coin_25 = c25;
    instr_ready = rdy;
    if (prog_done === 1'b1) seen_done++;
    if (coin_drop === 1'b1) seen_drops++;
    if (instr_valid === 1'b1) begin
      chk("instr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("instr", 32'(instr), 32'(exp_q[0].word));
        chk("rom_sel", 32'(rom_sel), 32'(exp_q[0].sel));
        if (rdy) begin
          void'(exp_q.pop_front());
          issued++;
        end
      end
    end
    @(posedge clk);
    #1;
    coin_5 = 1'b0;
    coin_10 = 1'b0;
    coin_25 = 1'b0;
  endtask

  // Coin cycle with model update; assumes the queue has room.
  task automatic coin_step(input logic c5, input logic c10, input logic c25, input logic rdy);
    if (c5 | c10 | c25) add_program(c25 ? 2'd2 : (c10 ? 2'd1 : 2'd0));
    if (int'(c5) + int'(c10) + int'(c25) > 1) exp_drops++;
    cycle(c5, c10, c25, rdy);
  endtask

  task automatic drain(input bit rand_ready);
    bit idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy === 1'b0 && pending === 4'd0 && instr_valid === 1'b0) begin
        idle = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0, 1'b0, rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
    chk("drain_idle", 32'(idle), 32'd1);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("prog_done_count", 32'(seen_done), 32'(exp_done));
    chk("coin_drop_count", 32'(seen_drops), 32'(exp_drops));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_prog_done"}, 32'(prog_done), 32'd0);
    chk({tag, "_coin_drop"}, 32'(coin_drop), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
  endtask

  initial begin
    int done_pre;
    bit got_done;
    rst = 1'b0;
    coin_5 = 1'b0;
    coin_10 = 1'b0;
    coin_25 = 1'b0;
    instr_ready = 1'b0;
    for (int c = 0; c < 4; c++) for (int a = 0; a < 8; a++) rom[c][a] = 19'h0;
    rom[1][0] = EndMark; rom[1][1] = 19'h7100a; rom[1][2] = 19'h04140; rom[1][3] = EndMark;
    rom[0][1] = 19'h11111; rom[0][2] = 19'h22222; rom[0][3] = EndMark;
    for (int a = 1; a < 8; a++) rom[2][a] = 19'h00100 + 19'(a);

    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single dime, captured on the first post-reset edge.
    coin_step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("dime_pending", 32'(pending), 32'd1);
    chk("dime_busy0", 32'(busy), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dime_busy1", 32'(busy), 32'd1);
    chk("dime_rom_sel", 32'(rom_sel), 32'd1);
    chk("dime_rom_addr", 32'(rom_addr), 32'd1);
    chk("dime_pending_pop", 32'(pending), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dime_valid_latency", 32'(instr_valid), 32'd1);
    chk("dime_first_instr", 32'(instr), 32'h7100a);
    drain(1'b0);

    // Quarter and nickel together: quarter wins, one drop pulse.
    coin_step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("pri_pending", 32'(pending), 32'd1);
    chk("pri_drop", 32'(coin_drop), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pri_drop_clear", 32'(coin_drop), 32'd0);
    chk("pri_rom_sel", 32'(rom_sel), 32'd2);
    drain(1'b0);

    // Five dimes while stalled fill the queue; a sixth is dropped.
    for (int i = 0; i < 5; i++) coin_step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("fill_pending", 32'(pending), 32'd4);
    chk("fill_no_drop", 32'(coin_drop), 32'd0);
    exp_drops++;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_drop", 32'(coin_drop), 32'd1);
    chk("full_pending", 32'(pending), 32'd4);
    drain(1'b0);

    // Stall five cycles in ISSUE, then release.
    coin_step(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", 32'(instr), 32'h11111);
      chk("stall_addr", 32'(rom_addr), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_valid", 32'(instr_valid), 32'd0);
    chk("release_addr", 32'(rom_addr), 32'd2);
    drain(1'b0);

    // No end marker: seven words, address stops at 7.
    issued = 0;
    coin_step(1'b0, 1'b0, 1'b1, 1'b1);
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (prog_done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("full_prog_done", 32'(got_done), 32'd1);
    chk("full_prog_addr", 32'(rom_addr), 32'd7);
    drain(1'b0);
    chk("full_prog_issued", 32'(issued), 32'd7);

    // Reset between edges during ISSUE with a coin still queued.
    done_pre = exp_done;
    coin_step(1'b0, 1'b1, 1'b0, 1'b0);
    coin_step(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    chk("pre_rst_pending", 32'(pending), 32'd1);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    exp_done = done_pre;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_no_done", 32'(seen_done), 32'(exp_done));
    drain(1'b0);

    // Random bursts of at most four accepted coins, so the queue never overflows.
    for (int b = 0; b < 25; b++) begin
      for (int c = 0; c < 3; c++) begin
        for (int a = 0; a < 8; a++) begin
          rom[c][a] = ($urandom_range(0, 4) == 0) ? EndMark : 19'($urandom);
        end
      end
      for (int k = $urandom_range(1, 4); k > 0; k--) begin
        logic [2:0] v;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, 3) != 0);
        end
        v = 3'($urandom_range(1, 7));
        coin_step(v[0], v[1], v[2], $urandom_range(0, 3) != 0);
      end
      drain(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
